// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared constants and state encoding for the sequence command
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int HDR_BYTES    = 3;
    localparam int MAX_LEN      = 255;
    localparam int MAX_PKT      = HDR_BYTES + MAX_LEN;
    localparam int SPACE_MARGIN = 2;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_HDR  = 5'b00010,
        ST_DATA = 5'b00100,
        ST_PAD  = 5'b01000,
        ST_DONE = 5'b10000
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [1:0]         gnt_idx_o
);

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = 2'd0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            if (req_i[(int'(ptr_i) + off) % NUM_SRC]) begin
                gnt_o                                  = '0;
                gnt_o[(int'(ptr_i) + off) % NUM_SRC]   = 1'b1;
                gnt_idx_o                              = 2'((int'(ptr_i) + off) % NUM_SRC);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sequence_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sequence_cmd_arbiter
// Description : Round-robin packet arbiter sharing the sequence FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_cmd_arbiter
    import seq_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W    = 9,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           seq_wrfifo_data,
    output logic                 seq_wrfifo_req,
    input  logic                 seq_wrfifo_full,
    input  logic [USEDW_W-1:0]   seq_wrfifo_usedw,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 timeout_err
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [7:0]         data_cnt_q, data_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               wr_req_q, wr_req_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               pkt_done_q, pkt_done_d;
    logic               tmo_err_q, tmo_err_d;

    logic [NUM_SRC-1:0] w_rr_gnt;
    logic [1:0]         w_rr_idx;
    logic               w_space_ok;
    logic               w_xfer;
    logic               w_pad_last;
    logic [7:0]         w_src_byte;

    rr_arbiter #(
        .NUM_SRC   (NUM_SRC)
    ) u_rr_arbiter (
        .req_i     (src_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (w_rr_gnt),
        .gnt_idx_o (w_rr_idx)
    );

    // Margin covers writes still in flight when usedw is sampled.
    assign w_space_ok = (FIFO_DEPTH - int'(seq_wrfifo_usedw)) >= (MAX_PKT + SPACE_MARGIN);
    assign w_xfer     = |(src_valid & src_ready);

    always_comb begin
        src_ready  = '0;
        w_src_byte = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 2'(i)) begin
                w_src_byte   = src_data[8*i +: 8];
                src_ready[i] = ((state_q == ST_HDR) || (state_q == ST_DATA)) && !seq_wrfifo_full;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        hdr_cnt_d  = hdr_cnt_q;
        data_cnt_d = data_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        wr_req_d   = 1'b0;
        wr_data_d  = 8'h00;
        pkt_done_d = 1'b0;
        tmo_err_d  = 1'b0;
        w_pad_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((|w_rr_gnt) && w_space_ok) begin
                    grant_d    = w_rr_idx;
                    hdr_cnt_d  = 2'd0;
                    data_cnt_d = 8'd0;
                    tmo_cnt_d  = '0;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR, ST_DATA: begin
                if (w_xfer) begin
                    wr_req_d  = 1'b1;
                    wr_data_d = w_src_byte;
                    tmo_cnt_d = '0;
                    if (state_q == ST_HDR) begin
                        if (hdr_cnt_q == 2'd1) begin
                            data_cnt_d = w_src_byte;
                        end
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                            state_d = (data_cnt_q != 8'd0) ? ST_DATA : ST_DONE;
                        end
                    end else begin
                        data_cnt_d = data_cnt_q - 8'd1;
                        if (data_cnt_q == 8'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (!seq_wrfifo_full) begin
                    if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d   = ST_PAD;
                        tmo_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
            end
            ST_PAD: begin
                // Missing header bytes are padded first, then missing data.
                if (!seq_wrfifo_full) begin
                    wr_req_d = 1'b1;
                    if (hdr_cnt_q != 2'(HDR_BYTES)) begin
                        hdr_cnt_d  = hdr_cnt_q + 2'd1;
                        w_pad_last = (hdr_cnt_q == 2'(HDR_BYTES - 1)) && (data_cnt_q == 8'd0);
                    end else begin
                        data_cnt_d = data_cnt_q - 8'd1;
                        w_pad_last = (data_cnt_q == 8'd1);
                    end
                    if (w_pad_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                pkt_done_d = 1'b1;
                rr_ptr_d   = (grant_q == 2'(NUM_SRC - 1)) ? 2'd0 : grant_q + 2'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 2'd0;
            grant_q    <= 2'd0;
            hdr_cnt_q  <= 2'd0;
            data_cnt_q <= 8'd0;
            tmo_cnt_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= 8'h00;
            pkt_done_q <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            hdr_cnt_q  <= hdr_cnt_d;
            data_cnt_q <= data_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            pkt_done_q <= pkt_done_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign seq_wrfifo_data = wr_data_q;
    assign seq_wrfifo_req  = wr_req_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != ST_IDLE);
    assign pkt_done        = pkt_done_q;
    assign timeout_err     = tmo_err_q;

endmodule
`default_nettype wire

// File: doc/sequence_cmd_arbiter.md
Name: sequence_cmd_arbiter

Overview:
- Shares the single write port of the sequence command FIFO between NUM_SRC byte-stream command sources (e.g. UART host, SPI host).
- Its output feeds the FIFO that customized_sequence_ctrl drains.
- Forwards whole packets atomically, granting sources in round-robin order:
  - packet = number byte, length byte, cycle byte, then `length` data bytes.
- Admits a packet only when the FIFO can hold the largest possible packet.
- Pads stalled packets so the downstream parser never sees a partial packet.

Parameters:
NUM_SRC, 2, number of command sources (2..4)
FIFO_DEPTH, 512, sequence FIFO depth in bytes
USEDW_W, 9, width of FIFO used-word count
TIMEOUT, 1024, max idle cycles inside a granted packet before padding

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
src_valid  in  NUM_SRC  per-source byte valid
src_data  in  8*NUM_SRC  per-source byte, source i at [8i+7:8i]
src_ready  out  NUM_SRC  per-source accept, combinational
seq_wrfifo_data  out  8  byte to sequence FIFO, registered
seq_wrfifo_req  out  1  FIFO write strobe, registered
seq_wrfifo_full  in  1  FIFO full
seq_wrfifo_usedw  in  USEDW_W  FIFO occupancy
grant_id  out  2  currently/last granted source
busy  out  1  packet in progress
pkt_done  out  1  one-cycle pulse after last byte of a packet is written
timeout_err  out  1  one-cycle pulse when padding starts

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (ports clk, rst).

Reset:
- All outputs 0.
- State IDLE; rr_ptr=0; byte counter=0; timeout counter=0.
- Reset mid-packet abandons the packet immediately with no further writes. FIFO recovery is the system reset's job.

Constants:
- MAX_PKT = 258 (3 + 255).
- space_ok = (FIFO_DEPTH - seq_wrfifo_usedw) >= MAX_PKT + 2. The +2 margin covers writes in flight.

FSM:
- IDLE: if any src_valid and space_ok, pick the first valid source starting at rr_ptr (wrapping). Latch grant_id, go HDR.
  - No valid source or !space_ok: stay.
- HDR: accept 3 bytes from the granted source; capture byte1 as pkt_len. After the 3rd byte: DATA if pkt_len != 0, else DONE.
- DATA: accept pkt_len bytes (8-bit down-counter), then DONE.
- PAD: write 0x00 bytes, one per cycle while !seq_wrfifo_full, until the remaining header+data count reaches 0, then DONE.
  - If the timeout hit during HDR before length was captured, pkt_len=0 is used. Only missing header bytes are padded.
- DONE: pulse pkt_done; rr_ptr <= grant_id+1 (mod NUM_SRC); go IDLE. Adds one bubble cycle between packets.

Handshake:
- src_ready[i] = (state in HDR/DATA) && grant_id==i && !seq_wrfifo_full.
- A byte transfers when src_valid & src_ready. Next cycle: seq_wrfifo_req=1, seq_wrfifo_data=that byte (1-cycle latency).
- Non-granted sources see src_ready=0 and must hold.
- seq_wrfifo_full stalls both forwarding and padding. No write is ever issued while full is sampled high.

Timeout:
- Counter clears on every accepted byte and increments each HDR/DATA cycle without a transfer.
- On reaching TIMEOUT-1: go PAD, pulse timeout_err.
- Full-stall cycles do not count.

Error handling:
- Byte values (number>3, length 0, cycle 0) are not checked; the downstream parser flags them.
- length 0 is forwarded as a 3-byte packet.

Simultaneous requests:
- Strict round-robin.
- A source whose packet completes has lowest priority for the next grant.

Other:
- busy = state != IDLE.

Decomposition:
- Shared package seq_pkg: HDR_BYTES=3, MAX_LEN=255, MAX_PKT=258, state encoding constants (one-hot, 5 states).
- One sub-module, rr_arbiter: NUM_SRC request vector plus pointer in, one-hot grant plus index out, combinational.

Test Plan:
1. Src0 sends {1,4,2,b1,b0,b1,b1}, usedw=0 → 7 writes with identical bytes in order, one cycle after each handshake; pkt_done one cycle after the last write; grant_id=0.
2. Both sources valid from cycle 0, each with a length-2 packet, rr_ptr=0 → src0 packet (5 bytes) fully written, bubble, then src1 packet; no byte interleaving; then rr_ptr=0.
3. usedw=FIFO_DEPTH-259 with src0 valid → no grant, src_ready=0. usedw drops to FIFO_DEPTH-260 → grant next cycle.
4. Src1 sends {2,6,1,...} but stops after 2 data bytes, TIMEOUT=16 → timeout_err pulse after 16 idle cycles; 4 bytes of 0x00 padded; total 9 writes; pkt_done.
5. seq_wrfifo_full asserted for 5 cycles mid-DATA → src_ready low, no writes, timeout counter frozen; transfer resumes with no byte lost or duplicated.
6. rst asserted in DATA after 3 data bytes → next cycle all outputs 0, state IDLE; a new length-0 packet from src0 afterwards → exactly 3 writes, then pkt_done.
